// File: rtl/hex_display_arbiter_if.sv
// hex_display_arbiter_if: requester/display bundle for the HEX3..HEX0 arbiter.
//  req   requester -> arbiter  per-requester level request
//  seg   requester -> arbiter  requester k segments at [28k+27:28k] = {HEX3,HEX2,HEX1,HEX0}, active-low
//  gnt   arbiter -> requester  one-hot grant, zero when nobody owns the display
//  owner arbiter -> requester  index of current owner, valid while busy
//  busy  arbiter -> requester  1 while a grant is asserted
//  hex3..hex0 arbiter -> pins  registered active-low segments, 7'h7F = off
interface hex_display_arbiter_if #(parameter int NREQ = 2);
  logic [NREQ-1:0] req;
  logic [NREQ*28-1:0] seg;
  logic [NREQ-1:0] gnt;
  logic [1:0] owner;
  logic busy;
  logic [6:0] hex3, hex2, hex1, hex0;
  modport master (output req, seg, input gnt, owner, busy, hex3, hex2, hex1, hex0);
  modport slave (input req, seg, output gnt, owner, busy, hex3, hex2, hex1, hex0);
endinterface

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: round-robin sharing of HEX3..HEX0 between NREQ requesters with hold-timer preemption.
//  CLOCK_50  system clock, rising edge
//  RESET_N   synchronous reset, active-low
//  bus       hex_display_arbiter_if.slave (req/seg in; gnt/owner/busy/hex3..hex0 out)
//  Optional macro HEX_ARB_BLANK_EN: owner changes pass through BLANK_CYCLES blank cycles.
module hex_display_arbiter #(
  parameter int NREQ = 2,
  parameter int MAX_HOLD = 50_000_000,
  parameter int CNT_W = 26,
  parameter int BLANK_CYCLES = 1_000
) (
  input logic CLOCK_50,
  input logic RESET_N,
  hex_display_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, BLANK} state_t;
  if (NREQ < 2 || NREQ > 4 || 2**CNT_W <= MAX_HOLD || BLANK_CYCLES < 1) begin : g_bad_cfg
    $error("hex_display_arbiter: illegal parameters");
  end
  state_t state, state_n;
  logic [NREQ-1:0] gnt, gnt_n;
  logic [1:0] owner, owner_n, rr_last, rr_n, pick;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [27:0] hex;
  logic others, own_req, go;
  int d, best;
`ifdef HEX_ARB_BLANK_EN
  logic [CNT_W-1:0] blank_cnt, blank_n;
`endif
  assign others = |(bus.req & ~gnt);
  assign own_req = |(bus.req & gnt);
  // Round-robin: smallest distance past rr_last wins, rr_last itself comes last.
  always_comb begin
    pick = '0;
    best = NREQ;
    d = 0;
    for (int k = 0; k < NREQ; k++) begin
      d = (k + 2 * NREQ - 1 - int'(rr_last)) % NREQ;
      if (bus.req[k] && d < best) begin
        best = d;
        pick = 2'(k);
      end
    end
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    owner_n = owner;
    rr_n = rr_last;
    hold_n = hold_cnt;
    go = 1'b0;
`ifdef HEX_ARB_BLANK_EN
    blank_n = blank_cnt;
`endif
    case (state)
      IDLE: go = |bus.req;
      GRANT:
        // Release wins over an expiring timer; both hand off the same way.
        if (!own_req || (others && hold_cnt == CNT_W'(MAX_HOLD - 1))) begin
          if (others) begin
`ifdef HEX_ARB_BLANK_EN
            state_n = BLANK;
            gnt_n = '0;
            blank_n = '0;
`else
            go = 1'b1;
`endif
          end else begin
            state_n = IDLE;
            gnt_n = '0;
          end
        end else if (others) hold_n = hold_cnt + 1'b1;
`ifdef HEX_ARB_BLANK_EN
      BLANK:
        if (blank_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          go = |bus.req;
          state_n = IDLE;
        end else blank_n = blank_cnt + 1'b1;
`endif
      default: state_n = IDLE;
    endcase
    if (go) begin
      state_n = GRANT;
      gnt_n = NREQ'(1) << pick;
      owner_n = pick;
      rr_n = pick;
      hold_n = '0;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      rr_last <= 2'(NREQ - 1);
      hold_cnt <= '0;
      hex <= '1;
`ifdef HEX_ARB_BLANK_EN
      blank_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      owner <= owner_n;
      rr_last <= rr_n;
      hold_cnt <= hold_n;
      hex <= |gnt ? bus.seg[28 * owner +: 28] : '1;
`ifdef HEX_ARB_BLANK_EN
      blank_cnt <= blank_n;
`endif
    end
  end
  assign bus.gnt = gnt;
  assign bus.owner = owner;
  assign bus.busy = |gnt;
  assign {bus.hex3, bus.hex2, bus.hex1, bus.hex0} = hex;
endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter: directed and randomized checks of hex_display_arbiter against a behavioural model.
`timescale 1ns/1ps
module tb_hex_display_arbiter;
  localparam int NREQ = 2, MAX_HOLD = 8, CNT_W = 4, BLANK_CYCLES = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0;
  int m_owner = -1, m_rr = NREQ - 1, m_hold = 0, m_blank = 0;
  logic [27:0] m_hex = '1;
  logic [27:0] hex_all;
  hex_display_arbiter_if #(.NREQ(NREQ)) bus ();
  hex_display_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );
  assign hex_all = {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  always #5 clk = ~clk;
  function automatic int rr_pick(int last, logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction
  function automatic logic [NREQ-1:0] exp_gnt();
    return m_owner < 0 ? '0 : NREQ'(1) << m_owner;
  endfunction
  // One clock edge: advance the model with the inputs the DUT sees, then settle.
  task automatic tick();
    int p;
    logic contend;
    @(posedge clk);
    if (!rst_n) begin
      m_owner = -1;
      m_rr = NREQ - 1;
      m_hold = 0;
      m_blank = 0;
      m_hex = '1;
    end else begin
      m_hex = m_owner < 0 ? '1 : bus.seg[28 * m_owner +: 28];
      p = rr_pick(m_rr, bus.req);
      contend = m_owner >= 0 && (bus.req & ~exp_gnt()) != '0;
      if (m_blank > 0) begin
        m_blank--;
        if (m_blank == 0 && p >= 0) begin m_owner = p; m_rr = p; m_hold = 0; end
      end else if (m_owner < 0) begin
        if (p >= 0) begin m_owner = p; m_rr = p; m_hold = 0; end
      end else if (!bus.req[m_owner] || (contend && m_hold == MAX_HOLD - 1)) begin
        if (!contend) m_owner = -1;
`ifdef HEX_ARB_BLANK_EN
        else begin m_owner = -1; m_blank = BLANK_CYCLES; end
`else
        else begin m_owner = p; m_rr = p; m_hold = 0; end
`endif
      end else if (contend) m_hold++;
    end
    #1;
  endtask
  task automatic do_reset(input logic [NREQ-1:0] r);
    bus.req = r;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    bus.req = 2'b11;
    bus.seg = 56'h0123456_789ABCD;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.owner !== 2'd0 || hex_all !== {4{7'h7F}}) begin
        fails++;
        $display("FAIL reset[%0d]: gnt=%b busy=%b owner=%0d hex=%h, expected 00/0/0/%h", i, bus.gnt, bus.busy, bus.owner, hex_all, {4{7'h7F}});
      end
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (bus.gnt !== 2'b01) begin fails++; $display("FAIL reset_first_grant: gnt=%b, expected 01", bus.gnt); end
    tick();
    tests++;
    if (bus.hex0 !== 7'h4D) begin fails++; $display("FAIL reset_first_hex0: hex0=%h, expected 4d", bus.hex0); end
  endtask
  task automatic test_solo();
    bus.seg = '0;
    do_reset(2'b01);
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if (bus.gnt !== 2'b01 || (i > 0 && hex_all !== 28'h0)) begin
        fails++;
        $display("FAIL solo[%0d]: gnt=%b hex=%h, expected gnt=01 hex=0000000", i, bus.gnt, hex_all);
      end
    end
  endtask
  task automatic test_alternate();
    logic [1:0] want;
    bus.seg = 56'h1111111_2222222;
    do_reset(2'b11);
    for (int c = 0; c < 48; c++) begin
      tick();
`ifdef HEX_ARB_BLANK_EN
      want = (c % 24) < 8 ? 2'b01 : (c % 24) < 12 ? 2'b00 : (c % 24) < 20 ? 2'b10 : 2'b00;
`else
      want = ((c / 8) % 2 == 0) ? 2'b01 : 2'b10;
`endif
      tests++;
      if (bus.gnt !== want || hex_all !== m_hex) begin
        fails++;
        $display("FAIL alternate[%0d]: gnt=%b hex=%h, expected gnt=%b hex=%h", c, bus.gnt, hex_all, want, m_hex);
      end
    end
  endtask
  task automatic test_release();
    bus.seg = 56'h3456789_0ABCDEF;
    do_reset(2'b11);
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (bus.gnt !== 2'b01) begin fails++; $display("FAIL release_hold[%0d]: gnt=%b, expected 01", i, bus.gnt); end
    end
    bus.req = 2'b10;
    tick();
`ifdef HEX_ARB_BLANK_EN
    tests++;
    if (bus.gnt !== 2'b00) begin fails++; $display("FAIL release_handoff: gnt=%b, expected 00", bus.gnt); end
    repeat (BLANK_CYCLES) tick();
    tests++;
    if (bus.gnt !== 2'b10) begin fails++; $display("FAIL release_after_blank: gnt=%b, expected 10", bus.gnt); end
`else
    tests++;
    if (bus.gnt !== 2'b10) begin fails++; $display("FAIL release_handoff: gnt=%b, expected 10", bus.gnt); end
`endif
    tick();
    tests++;
    if (hex_all !== 28'h3456789) begin fails++; $display("FAIL release_hex: hex=%h, expected 3456789", hex_all); end
  endtask
  task automatic test_reset_mid();
    bus.seg = 56'h5555555_6666666;
    do_reset(2'b10);
    repeat (3) tick();
    tests++;
    if (bus.gnt !== 2'b10 || bus.owner !== 2'd1) begin fails++; $display("FAIL mid_owner1: gnt=%b owner=%0d, expected 10/1", bus.gnt, bus.owner); end
    rst_n = 1'b0;
    tick();
    tests++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || hex_all !== {4{7'h7F}}) begin
      fails++;
      $display("FAIL mid_reset: gnt=%b busy=%b hex=%h, expected 00/0/%h", bus.gnt, bus.busy, hex_all, {4{7'h7F}});
    end
    rst_n = 1'b1;
    bus.req = 2'b11;
    tick();
    tests++;
    if (bus.gnt !== 2'b01 || bus.owner !== 2'd0) begin fails++; $display("FAIL mid_rr_restart: gnt=%b owner=%0d, expected 01/0", bus.gnt, bus.owner); end
  endtask
  task automatic test_random();
    do_reset(2'b00);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++) if ($urandom_range(0, 9) == 0) bus.req[k] = ~bus.req[k];
      if ($urandom_range(0, 3) == 0) bus.seg = 56'({$urandom(), $urandom()});
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
      tests++;
      if (bus.gnt !== exp_gnt() || bus.busy !== (m_owner >= 0) || (m_owner >= 0 && bus.owner !== 2'(m_owner)) || hex_all !== m_hex) begin
        fails++;
        $display("FAIL random[%0d]: gnt=%b busy=%b owner=%0d hex=%h, expected gnt=%b owner=%0d hex=%h", c, bus.gnt, bus.busy, bus.owner, hex_all, exp_gnt(), m_owner, m_hex);
      end
    end
  endtask
  initial begin
    bus.req = '0;
    bus.seg = '0;
    test_reset();
    test_solo();
    test_alternate();
    test_release();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
